// File: rtl/carryskip_adder8.sv
// 8-bit carry-skip adder in the tiny-tapeout wrapper: A on ui_in, B on uio_in,
// registered (A+B) mod 256 on uo_out; two 4-bit ripple blocks joined by a bypass mux.
module carryskip_adder8 #(
  parameter int WIDTH = 8,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] ui_in,
  input  logic [WIDTH-1:0] uio_in,
  output logic [WIDTH-1:0] uo_out,
  output logic [WIDTH-1:0] uio_out,
  output logic [WIDTH-1:0] uio_oe
);

  localparam int NBLK = WIDTH / BLK;

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] core_sum;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;

  assign p    = ui_in ^ uio_in;
  assign g    = ui_in & uio_in;
  assign c[0] = 1'b0;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NBLK; gi++) begin : g_blk
      logic [BLK:0] rip;
      logic         blk_p;

      assign rip[0] = c[gi*BLK];
      for (gj = 0; gj < BLK; gj++) begin : g_bit
        assign rip[gj+1] = g[gi*BLK+gj] | (p[gi*BLK+gj] & rip[gj]);
        assign core_sum[gi*BLK+gj] = p[gi*BLK+gj] ^ rip[gj];
      end

      // A fully propagating block forwards its carry-in directly; otherwise
      // the ripple carry-out is already correct, so the value never changes.
      assign blk_p = &p[gi*BLK +: BLK];
      assign c[(gi+1)*BLK] = blk_p ? c[gi*BLK] : rip[BLK];

      for (gj = 1; gj < BLK; gj++) begin : g_int
        assign c[gi*BLK+gj] = rip[gj];
      end
    end
  endgenerate

  // The final carry c[WIDTH] is not brought out; the sum wraps mod 2^WIDTH.
  logic unused_cout;
  assign unused_cout = c[WIDTH];

  always_comb begin
    sum_d = sum_q;
    if (ena) begin
      sum_d = core_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign uo_out  = sum_q;
  assign uio_out = {WIDTH{unused_cout & 1'b0}};
  assign uio_oe  = '0;

endmodule

// File: tb/tb_carryskip_adder8.sv
// Scoreboard bench for carryskip_adder8: the driver pushes expected sums,
// a monitor pops one per clock edge and compares against uo_out.
module tb_carryskip_adder8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];

  carryskip_adder8 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; the expected result is what the
  // register must hold after the following rising edge.
  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic en,
                       input logic [7:0] exp, input bit verbose);
    @(negedge clk);
    ui_in  = a;
    uio_in = b;
    ena    = en;
    sb_q.push_back(exp);
    if (verbose) $display("txn a=%h b=%h ena=%0d expect=%h", a, b, en, exp);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      check("sum", uo_out, sb_q.pop_front());
      check("uio_out", uio_out, 8'h00);
      check("uio_oe", uio_oe, 8'h00);
    end
  end

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < 10) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL %s drain actual=%0d pending required=0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    // 1: held in reset with random operands
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ui_in  = 8'($urandom);
      uio_in = 8'($urandom);
      #1;
      check("reset_uo", uo_out, 8'h00);
      check("reset_oe", uio_oe, 8'h00);
      check("reset_uio_out", uio_out, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;

    drive(8'h0F, 8'h01, 1'b1, 8'h10, 1'b1);
    // 2, 3
    drive(8'hFF, 8'h01, 1'b1, 8'h00, 1'b1);
    drive(8'h55, 8'hAA, 1'b1, 8'hFF, 1'b1);
    drive(8'h80, 8'h80, 1'b1, 8'h00, 1'b1);
    drive(8'h7F, 8'h01, 1'b1, 8'h80, 1'b1);
    drive(8'h12, 8'h34, 1'b1, 8'h46, 1'b1);
    drive(8'hF0, 8'h0F, 1'b1, 8'hFF, 1'b1);
    drive(8'hF0, 8'h10, 1'b1, 8'h00, 1'b1);
    // 4: enable hold
    drive(8'h20, 8'h03, 1'b1, 8'h23, 1'b1);
    for (int i = 0; i < 3; i++) drive(8'hFF, 8'hFF, 1'b0, 8'h23, 1'b1);
    drive(8'hFF, 8'hFF, 1'b1, 8'hFE, 1'b1);
    wait_drain("directed");

    // 5: asynchronous reset between edges
    @(posedge clk);
    #3;
    check("pre_reset", uo_out, 8'hFE);
    rst_n = 1'b0;
    #1;
    check("async_clear", uo_out, 8'h00);
    $display("txn async reset pulse uo_out=%h", uo_out);
    @(posedge clk);
    #1;
    check("reset_hold_edge", uo_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("after_release", uo_out, 8'h00);

    // 6: exhaustive sweep
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        drive(8'(a), 8'(b), 1'b1, 8'((a + b) & 8'hFF), 1'b0);
      end
    end
    wait_drain("sweep");
    $display("txn sweep done 65536 vectors");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
